load_writeback: RTL

LOAD_WRITEBACK -- requirements
Module: load_writeback

---
 rtl/load_writeback.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/load_writeback.sv
// Load/writeback stage: formats load data from memory and drives the
// register-file write port. Non-load results are forwarded with one cycle of
// latency. Loads wait for a one-cycle memory response, and a bounded counter
// aborts the wait if the response never arrives.
module load_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        load_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  // Counter value seen on the last WAIT cycle that is still allowed to
  // receive a response; the counter starts at 0 on the first WAIT cycle.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we3_q, we3_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;
  logic        err_q, err_d;

  // Misaligned half/word accesses and unused funct3 codes are rejected.
  function automatic logic loadIsBad(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = lo[0];
      3'b010:         bad = (lo != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the byte or half lane from the aligned word and extend it.
  function automatic logic [31:0] formatLoad(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] res;
    case (lo)
      2'd0:    byteLane = word[7:0];
      2'd1:    byteLane = word[15:8];
      2'd2:    byteLane = word[23:16];
      default: byteLane = word[31:24];
    endcase
    halfLane = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{byteLane[7]}}, byteLane};
      3'b001:  res = {{16{halfLane[15]}}, halfLane};
      3'b010:  res = word;
      3'b100:  res = {24'd0, byteLane};
      3'b101:  res = {16'd0, halfLane};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Ops are only taken while no load is outstanding.
  assign in_ready = (state_q == IDLE);

  // Next-state and next-output logic; write/error strobes default to idle.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    we3_d      = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!in_is_load) begin
            we3_d = in_regwrite && (in_rd != 5'd0);
            a3_d  = in_rd;
            wd3_d = in_result;
          end else if (loadIsBad(in_funct3, in_addr_lo)) begin
            err_d = 1'b1;
          end else begin
            rd_d       = in_rd;
            regwrite_d = in_regwrite;
            funct3_d   = in_funct3;
            addr_d     = in_addr_lo;
            cnt_d      = 8'd0;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          we3_d   = regwrite_q && (rd_q != 5'd0);
          a3_d    = rd_q;
          wd3_d   = formatLoad(funct3_q, addr_q, mem_rdata);
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == LAST_COUNT) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered write-port outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q    <= IDLE;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 2'd0;
      cnt_q      <= 8'd0;
      we3_q      <= 1'b0;
      a3_q       <= 5'd0;
      wd3_q      <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      we3_q      <= we3_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      err_q      <= err_d;
    end
  end

  assign WE3      = we3_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign load_err = err_q;

endmodule
